// File: rtl/dm_sba_bridge.sv
// dm_sba_bridge: adapts the debug module SBA req/gnt/r_valid master port to
// decoupled valid/ready request and response channels. It tracks a single
// outstanding transaction and bounds the response wait with a timeout. A
// sticky error report ensures the debugger never hangs on a dead bus.
module dm_sba_bridge #(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // SBA engine side
  input  logic                  sba_req_i,
  input  logic [BusWidth-1:0]   sba_add_i,
  input  logic                  sba_we_i,
  input  logic [BusWidth-1:0]   sba_wdata_i,
  input  logic [BusWidth/8-1:0] sba_be_i,
  output logic                  sba_gnt_o,
  output logic                  sba_r_valid_o,
  output logic [BusWidth-1:0]   sba_r_rdata_o,
  // request channel
  output logic                  a_valid_o,
  input  logic                  a_ready_i,
  output logic [BusWidth-1:0]   a_addr_o,
  output logic                  a_we_o,
  output logic [BusWidth-1:0]   a_wdata_o,
  output logic [BusWidth/8-1:0] a_be_o,
  // response channel
  input  logic                  d_valid_i,
  output logic                  d_ready_o,
  input  logic [BusWidth-1:0]   d_rdata_i,
  input  logic                  d_error_i,
  // sticky error report
  output logic                  err_o,
  output logic [1:0]            err_cause_o,
  input  logic                  err_clr_i
);

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Req     = 2'd1,
    WaitRsp = 2'd2,
    Respond = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CauseNone       = 2'd0,
    CauseBusError   = 2'd1,
    CauseTimeout    = 2'd2,
    CauseUnexpected = 2'd3
  } cause_e;

  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  a_valid_q;
  logic                  r_valid_q;
  logic [BusWidth-1:0]   rdata_q;
  logic [BusWidth-1:0]   addr_q;
  logic                  we_q;
  logic [BusWidth-1:0]   wdata_q;
  logic [BusWidth/8-1:0] be_q;
  logic                  err_q;
  cause_e                cause_q;

  logic                  timeout;
  logic                  new_err;
  cause_e                new_cause;

  // Timeout fires only when no response arrives in the same cycle.
  assign timeout = (state_q == WaitRsp) && !d_valid_i && (cnt_q == TimeoutLast);

  // Classify the error event raised this cycle, if any.
  always_comb begin
    new_err   = 1'b0;
    new_cause = CauseNone;
    if (d_valid_i) begin
      if (state_q != WaitRsp) begin
        new_err   = 1'b1;
        new_cause = CauseUnexpected;
      end else if (d_error_i) begin
        new_err   = 1'b1;
        new_cause = CauseBusError;
      end
    end else if (timeout) begin
      new_err   = 1'b1;
      new_cause = CauseTimeout;
    end
  end

  // Transaction FSM with registered request, response and handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= Idle;
      cnt_q     <= '0;
      a_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      unique case (state_q)
        Idle: begin
          r_valid_q <= 1'b0;
          if (sba_req_i) begin
            addr_q    <= sba_add_i;
            we_q      <= sba_we_i;
            wdata_q   <= sba_wdata_i;
            be_q      <= sba_be_i;
            a_valid_q <= 1'b1;
            state_q   <= Req;
          end
        end
        Req: begin
          if (a_ready_i) begin
            a_valid_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= WaitRsp;
          end
        end
        WaitRsp: begin
          cnt_q <= cnt_q + CntWidth'(1);
          if (d_valid_i) begin
            rdata_q   <= we_q ? '0 : d_rdata_i;
            r_valid_q <= 1'b1;
            state_q   <= Respond;
          end else if (timeout) begin
            rdata_q   <= '0;
            r_valid_q <= 1'b1;
            state_q   <= Respond;
          end
        end
        Respond: begin
          r_valid_q <= 1'b0;
          state_q   <= Idle;
        end
        default: state_q <= Idle;
      endcase
    end
  end

  // Sticky error: first cause wins; a new error overrides a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q   <= 1'b0;
      cause_q <= CauseNone;
    end else if (new_err) begin
      err_q <= 1'b1;
      if (!err_q) begin
        cause_q <= new_cause;
      end
    end else if (err_clr_i) begin
      err_q   <= 1'b0;
      cause_q <= CauseNone;
    end
  end

  // Grant is combinational in Idle and suppressed while reset is held.
  assign sba_gnt_o     = (state_q == Idle) && sba_req_i && !rst_i;
  assign sba_r_valid_o = r_valid_q;
  assign sba_r_rdata_o = rdata_q;
  assign a_valid_o     = a_valid_q;
  assign a_addr_o      = addr_q;
  assign a_we_o        = we_q;
  assign a_wdata_o     = wdata_q;
  assign a_be_o        = be_q;
  assign d_ready_o     = 1'b1;
  assign err_o         = err_q;
  assign err_cause_o   = cause_q;

endmodule

// File: tb/tb_dm_sba_bridge.sv
// Testbench for dm_sba_bridge: scenario tasks with inline checks plus a
// response scoreboard fed when requests are issued.
module tb_dm_sba_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sba_req;
  logic [31:0] sba_add;
  logic        sba_we;
  logic [31:0] sba_wdata;
  logic [3:0]  sba_be;
  logic        sba_gnt;
  logic        sba_r_valid;
  logic [31:0] sba_r_rdata;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_addr;
  logic        a_we;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_error;
  logic        err;
  logic [1:0]  err_cause;
  logic        err_clr;

  int          errors = 0;
  int          checks = 0;
  int          rv_count = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  dm_sba_bridge #(.BusWidth(32), .TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .sba_req_i(sba_req), .sba_add_i(sba_add), .sba_we_i(sba_we),
    .sba_wdata_i(sba_wdata), .sba_be_i(sba_be), .sba_gnt_o(sba_gnt),
    .sba_r_valid_o(sba_r_valid), .sba_r_rdata_o(sba_r_rdata),
    .a_valid_o(a_valid), .a_ready_i(a_ready), .a_addr_o(a_addr),
    .a_we_o(a_we), .a_wdata_o(a_wdata), .a_be_o(a_be),
    .d_valid_i(d_valid), .d_ready_o(d_ready), .d_rdata_i(d_rdata),
    .d_error_i(d_error),
    .err_o(err), .err_cause_o(err_cause), .err_clr_i(err_clr)
  );

  // Scoreboard: every response pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (!rst && sba_r_valid) begin
      logic [31:0] e;
      rv_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_rvalid: rdata=%h, required no response", sba_r_rdata);
      end else begin
        e = exp_q.pop_front();
        if (sba_r_rdata !== e) begin
          errors++;
          $display("FAIL sb_rdata: got %h, required %h", sba_r_rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sba_req = 0; sba_add = '0; sba_we = 0; sba_wdata = '0;
    sba_be = '0; a_ready = 0; d_valid = 0; d_rdata = '0; d_error = 0;
    err_clr = 0;
    #2;
    checks++; if (sba_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b, required 0", sba_gnt); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b, required 0", a_valid); end
    checks++; if (sba_r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %b, required 0", sba_r_valid); end
    checks++; if (a_addr !== 32'h0) begin errors++; $display("FAIL reset_a_addr: got %h, required 0", a_addr); end
    checks++; if (sba_r_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", sba_r_rdata); end
    checks++; if ({err, err_cause} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b/%0d, required 0/0", err, err_cause); end
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL reset_d_ready: got %b, required 1", d_ready); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_read_zero_wait();
    // cycle 0: request, grant is combinational
    sba_req = 1; sba_add = 32'h1000; sba_we = 0; sba_be = 4'hF; a_ready = 1;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    checks++; if (sba_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b, required 1", sba_gnt); end
    step(); // cycle 1
    sba_req = 0;
    checks++; if (a_valid !== 1'b1 || a_addr !== 32'h1000 || a_we !== 1'b0) begin
      errors++; $display("FAIL rd_a_chan: valid=%b addr=%h we=%b, required 1/00001000/0", a_valid, a_addr, a_we);
    end
    checks++; if (sba_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt_busy: got %b, required 0", sba_gnt); end
    step(); // cycle 2
    d_valid = 1; d_rdata = 32'hDEADBEEF; d_error = 0;
    checks++; if (sba_r_valid !== 1'b0 || a_valid !== 1'b0) begin
      errors++; $display("FAIL rd_c2: r_valid=%b a_valid=%b, required 0/0", sba_r_valid, a_valid);
    end
    step(); // cycle 3
    d_valid = 0;
    checks++; if (sba_r_valid !== 1'b1 || sba_r_rdata !== 32'hDEADBEEF || err !== 1'b0) begin
      errors++; $display("FAIL rd_resp: r_valid=%b rdata=%h err=%b, required 1/deadbeef/0", sba_r_valid, sba_r_rdata, err);
    end
    step();
    checks++; if (sba_r_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b, required 0", sba_r_valid); end
  endtask

  task automatic test_write_backpressure();
    int rv0 = rv_count;
    sba_req = 1; sba_add = 32'h2000; sba_we = 1; sba_wdata = 32'h12345678;
    sba_be = 4'hF; a_ready = 0;
    exp_q.push_back(32'h0);
    #1;
    checks++; if (sba_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b, required 1", sba_gnt); end
    for (int i = 0; i < 6; i++) begin
      step();
      sba_req = 0; sba_add = 32'hFFFF; sba_wdata = 32'h0; sba_be = 4'h0;
      checks++;
      if (a_valid !== 1'b1 || a_addr !== 32'h2000 || a_we !== 1'b1 ||
          a_wdata !== 32'h12345678 || a_be !== 4'hF) begin
        errors++;
        $display("FAIL wr_stable[%0d]: valid=%b addr=%h we=%b wdata=%h be=%h, required 1/00002000/1/12345678/f",
                 i, a_valid, a_addr, a_we, a_wdata, a_be);
      end
      if (i == 5) a_ready = 1;
    end
    step();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL wr_a_drop: got %b, required 0", a_valid); end
    d_valid = 1; d_rdata = 32'hFFFF0000;
    step();
    d_valid = 0;
    checks++; if (sba_r_valid !== 1'b1 || sba_r_rdata !== 32'h0) begin
      errors++; $display("FAIL wr_resp: r_valid=%b rdata=%h, required 1/00000000", sba_r_valid, sba_r_rdata);
    end
    step(); step();
    checks++; if (rv_count - rv0 != 1) begin errors++; $display("FAIL wr_pulses: got %0d, required 1", rv_count - rv0); end
  endtask

  task automatic test_timeout();
    sba_req = 1; sba_add = 32'h3000; sba_we = 0; a_ready = 1;
    exp_q.push_back(32'h0);
    step(); sba_req = 0; // Req
    step();              // first WaitRsp cycle
    for (int k = 1; k < 8; k++) begin
      step();
      checks++; if (sba_r_valid !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: got %b, required 0", k, sba_r_valid); end
    end
    step();
    checks++; if (sba_r_valid !== 1'b1 || sba_r_rdata !== 32'h0 || err !== 1'b1 || err_cause !== 2'd2) begin
      errors++; $display("FAIL to_resp: r_valid=%b rdata=%h err=%b cause=%0d, required 1/00000000/1/2",
                         sba_r_valid, sba_r_rdata, err, err_cause);
    end
    step();
    d_valid = 1; d_rdata = 32'h77;
    step();
    d_valid = 0;
    #1;
    checks++; if (err !== 1'b1 || err_cause !== 2'd2 || sba_r_rdata !== 32'h0) begin
      errors++; $display("FAIL to_late: err=%b cause=%0d rdata=%h, required 1/2/00000000", err, err_cause, sba_r_rdata);
    end
    err_clr = 1;
    step();
    err_clr = 0;
    checks++; if (err !== 1'b0 || err_cause !== 2'd0) begin
      errors++; $display("FAIL to_clr: err=%b cause=%0d, required 0/0", err, err_cause);
    end
  endtask

  task automatic test_bus_error();
    sba_req = 1; sba_add = 32'h4000; sba_we = 0; a_ready = 1;
    exp_q.push_back(32'hAA);
    step(); sba_req = 0;
    step(); d_valid = 1; d_error = 1; d_rdata = 32'hAA;
    step(); d_valid = 0; d_error = 0;
    checks++; if (sba_r_valid !== 1'b1 || sba_r_rdata !== 32'hAA || err !== 1'b1 || err_cause !== 2'd1) begin
      errors++; $display("FAIL be_resp: r_valid=%b rdata=%h err=%b cause=%0d, required 1/000000aa/1/1",
                         sba_r_valid, sba_r_rdata, err, err_cause);
    end
    step();
    err_clr = 1;
    step();
    err_clr = 0;
  endtask

  task automatic test_unexpected();
    int rv0 = rv_count;
    d_valid = 1; d_rdata = 32'h99;
    step();
    d_valid = 0;
    #1;
    checks++; if (err !== 1'b1 || err_cause !== 2'd3 || sba_r_rdata !== 32'hAA) begin
      errors++; $display("FAIL ux_err: err=%b cause=%0d rdata=%h, required 1/3/000000aa", err, err_cause, sba_r_rdata);
    end
    err_clr = 1; d_valid = 1;
    step();
    err_clr = 0; d_valid = 0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ux_clr_race: err=%b, required 1", err); end
    step();
    checks++; if (rv_count != rv0) begin errors++; $display("FAIL ux_no_rvalid: pulses=%0d, required 0", rv_count - rv0); end
  endtask

  task automatic test_reset_mid();
    sba_req = 1; sba_add = 32'h5000; sba_we = 0; a_ready = 1;
    step(); sba_req = 0;
    step(); // WaitRsp
    rst = 1;
    #1;
    checks++; if (a_valid !== 0 || sba_r_valid !== 0 || a_addr !== 32'h0 || sba_r_rdata !== 32'h0 ||
                  err !== 0 || err_cause !== 2'd0 || sba_gnt !== 0) begin
      errors++; $display("FAIL rst_mid: a_valid=%b r_valid=%b addr=%h rdata=%h err=%b cause=%0d gnt=%b, required all 0",
                         a_valid, sba_r_valid, a_addr, sba_r_rdata, err, err_cause, sba_gnt);
    end
    step();
    rst = 0;
    step();
    d_valid = 1; d_rdata = 32'h5A;
    step();
    d_valid = 0;
    #1;
    checks++; if (err !== 1'b1 || err_cause !== 2'd3) begin
      errors++; $display("FAIL rst_inflight: err=%b cause=%0d, required 1/3", err, err_cause);
    end
    err_clr = 1;
    step();
    err_clr = 0;
    sba_req = 1; sba_add = 32'h3000; sba_we = 0;
    exp_q.push_back(32'h55);
    #1;
    checks++; if (sba_gnt !== 1'b1) begin errors++; $display("FAIL rst_regrant: got %b, required 1", sba_gnt); end
    step(); sba_req = 0;
    checks++; if (a_valid !== 1'b1 || a_addr !== 32'h3000) begin
      errors++; $display("FAIL rst_a_chan: valid=%b addr=%h, required 1/00003000", a_valid, a_addr);
    end
    step(); d_valid = 1; d_rdata = 32'h55;
    step(); d_valid = 0;
    checks++; if (sba_r_valid !== 1'b1 || sba_r_rdata !== 32'h55 || err !== 1'b0) begin
      errors++; $display("FAIL rst_resp: r_valid=%b rdata=%h err=%b, required 1/00000055/0", sba_r_valid, sba_r_rdata, err);
    end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_backpressure();
    test_timeout();
    test_bus_error();
    test_unexpected();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
